// File: rtl/pe_pkg.sv
// Shared definitions for the PE instruction path: decoder opcodes,
// sequencer state encoding and instruction word field offsets.
package pe_pkg;

    // Decoder opcodes; any encoding not listed here decodes as LOAD.
    localparam logic [2:0] OP_LOAD   = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_MULADD = 3'b101;
    localparam logic [2:0] OP_MULSUB = 3'b110;
    localparam logic [2:0] OP_MAX    = 3'b111;

    // Instruction word layout: {opcode, repeat}.
    localparam int OPC_W   = 3;
    localparam int REP_LSB = 0;

    // The opcode field sits directly above the repeat field.
    function automatic int opc_lsb(input int cnt_width);
        return REP_LSB + cnt_width;
    endfunction

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pe_inst_mem.sv
// Program storage for the instruction sequencer: synchronous write,
// asynchronous read, no reset so contents survive a sequencer reset.
module pe_inst_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per edge while enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_inst_sequencer.sv
// Instruction sequencer for one PE: replays a stored (opcode, repeat)
// program into the PE decoder, one instruction per cycle, honours stall,
// and waits out the decoder pipeline before pulsing done.
// Optional feature macro: PE_SEQ_LOOP_EN adds loop_cnt and replays the
// whole program loop_cnt+1 times before the single drain/done.
//
// state     | meaning
// ----------+--------------------------------------------------------
// SEQ_IDLE  | waiting for start; program writes accepted
// SEQ_ISSUE | issuing entries, each repeat+1 times; stall withholds
// SEQ_DRAIN | no issue; waiting PIPE_DELAY cycles for decoder results
// SEQ_DONE  | completion; done/busy reflect it on the following cycle
module pe_inst_sequencer
    import pe_pkg::*;
#(
    parameter int INST_DEPTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int PIPE_DELAY = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(INST_DEPTH)-1:0] prog_addr,
    input  logic [OPC_W+CNT_WIDTH-1:0]    prog_data,
    input  logic [$clog2(INST_DEPTH):0]   prog_len,
    input  logic                          start,
    input  logic                          stall,
`ifdef PE_SEQ_LOOP_EN
    input  logic [CNT_WIDTH-1:0]          loop_cnt,
`endif
    output logic                          inst_v,
    output logic [2:0]                    opcode,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(INST_DEPTH)-1:0] pc
);

    localparam int AW      = $clog2(INST_DEPTH);
    localparam int IW      = OPC_W + CNT_WIDTH;
    localparam int OPC_LSB = opc_lsb(CNT_WIDTH);
    localparam int DW      = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY + 1) : 1;

    seq_state_t           state;
    seq_state_t           state_nx;
    logic [AW:0]          len_q;
    logic [CNT_WIDTH-1:0] rep_cnt;
    logic [DW-1:0]        drain_cnt;
    logic [IW-1:0]        mem_rd;
    logic [2:0]           cur_opc;
    logic [CNT_WIDTH-1:0] cur_rep;
    logic                 mem_we;
    logic                 last_entry;
    logic                 last_pass;
    logic                 start_go;
    logic                 issue;
    logic                 entry_end;

    assign mem_we = prog_we && (state == SEQ_IDLE);

    pe_inst_mem #(
        .DEPTH (INST_DEPTH),
        .WIDTH (IW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (mem_rd)
    );

    assign cur_opc    = mem_rd[OPC_LSB +: OPC_W];
    assign cur_rep    = mem_rd[REP_LSB +: CNT_WIDTH];
    assign last_entry = ({1'b0, pc} == (len_q - 1'b1));

`ifdef PE_SEQ_LOOP_EN
    logic [CNT_WIDTH-1:0] loop_q;

    assign last_pass = (loop_q == '0);

    // Remaining passes: loaded on start, decremented at each pass wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop_q <= '0;
        end else if (start_go) begin
            loop_q <= loop_cnt;
        end else if (issue && entry_end && last_entry && !last_pass) begin
            loop_q <= loop_q - 1'b1;
        end
    end
`else
    assign last_pass = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and per-edge control strobes.
    always_comb begin
        state_nx  = state;
        start_go  = 1'b0;
        issue     = 1'b0;
        entry_end = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (start) begin
                    start_go = 1'b1;
                    state_nx = (prog_len == '0) ? SEQ_DONE : SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                if (!stall) begin
                    issue     = 1'b1;
                    entry_end = (rep_cnt == cur_rep);
                    if (entry_end && last_entry && last_pass) begin
                        state_nx = SEQ_DRAIN;
                    end
                end
            end
            SEQ_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nx = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                state_nx = SEQ_IDLE;
            end
            default: begin
                state_nx = SEQ_IDLE;
            end
        endcase
    end

    // Program position: pc and repeat counter advance on every issue;
    // pc returns to 0 after the last entry instead of stepping past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= '0;
            pc      <= '0;
            rep_cnt <= '0;
        end else if (start_go) begin
            len_q   <= prog_len;
            pc      <= '0;
            rep_cnt <= '0;
        end else if (issue) begin
            if (entry_end) begin
                rep_cnt <= '0;
                pc      <= last_entry ? '0 : pc + 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    // Drain timer: down-counter loaded as the final issue goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (issue && (state_nx == SEQ_DRAIN)) begin
            drain_cnt <= DW'(PIPE_DELAY - 1);
        end else if ((state == SEQ_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Registered decoder interface and status; opcode holds when not issuing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_v <= 1'b0;
            opcode <= OP_LOAD;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            inst_v <= issue;
            if (issue) begin
                opcode <= cur_opc;
            end
            busy <= (state != SEQ_IDLE);
            done <= (state == SEQ_DONE);
        end
    end

endmodule

// File: tb/tb_pe_inst_sequencer.sv
module tb_pe_inst_sequencer;

    localparam int DEPTH = 16;
    localparam int CW    = 8;
    localparam int PD    = 7;
    localparam int AW    = 4;
    localparam int IW    = 3 + CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          stall;
`ifdef PE_SEQ_LOOP_EN
    logic [CW-1:0] loop_cnt;
`endif
    logic          inst_v;
    logic [2:0]    opcode;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    int total = 0;
    int bad   = 0;

    logic [IW-1:0] mdl_mem [DEPTH];
    logic [2:0]    mdl_op;

    always #5 clk = ~clk;

    pe_inst_sequencer #(
        .INST_DEPTH (DEPTH),
        .CNT_WIDTH  (CW),
        .PIPE_DELAY (PD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .stall     (stall),
`ifdef PE_SEQ_LOOP_EN
        .loop_cnt  (loop_cnt),
`endif
        .inst_v    (inst_v),
        .opcode    (opcode),
        .busy      (busy),
        .done      (done),
        .pc        (pc)
    );

    task automatic write_entry(input int a, input logic [2:0] op, input int rep);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = {op, CW'(rep)};
        mdl_mem[a] = {op, CW'(rep)};
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    // Runs one program from start to done+1 and scores every cycle against
    // an issue list expanded from the model memory.
    task automatic replay(input int len, input int loops, input int stall_pct,
                          input int st_a, input int st_b,
                          input bit intrude, input bit wr_on_start);
        logic [2:0] q_op[$];
        int         q_pc[$];
        int         n;
        int         idx;
        int         done_j;
        int         epc;
        bit         finished;
        logic       s;
        logic       ev;
        logic       eb;
        logic       ed;
        logic [2:0] nop;
        int         nrep;

        @(negedge clk);
        start    = 1'b1;
        prog_len = (AW+1)'(len);
`ifdef PE_SEQ_LOOP_EN
        loop_cnt = CW'(loops);
`endif
        if (wr_on_start) begin
            nop  = 3'($urandom_range(0, 7));
            nrep = $urandom_range(0, 2);
            prog_we    = 1'b1;
            prog_addr  = '0;
            prog_data  = {nop, CW'(nrep)};
            mdl_mem[0] = {nop, CW'(nrep)};
        end
        for (int p = 0; p <= loops; p++) begin
            for (int e = 0; e < len; e++) begin
                for (int r = 0; r <= int'(mdl_mem[e][CW-1:0]); r++) begin
                    q_op.push_back(mdl_mem[e][IW-1:CW]);
                    q_pc.push_back(e);
                end
            end
        end
        n      = q_op.size();
        idx    = 0;
        done_j = (n == 0) ? 1 : -1;

        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        total++;
        if (inst_v !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== '0 || opcode !== mdl_op) begin
            bad++;
            $display("FAIL start_edge: inst_v=%b busy=%b done=%b pc=%0d op=%b, need 0 0 0 0 %b",
                     inst_v, busy, done, pc, opcode, mdl_op);
        end

        finished = 1'b0;
        for (int j = 1; j < 5000; j++) begin
            @(negedge clk);
            s = (j >= st_a && j <= st_b) ? 1'b1 : ($urandom_range(0, 99) < stall_pct);
            stall = s;
            if (intrude && j == 2) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = '0;
                prog_data = ~mdl_mem[0];
            end
            @(posedge clk);
            #1;
            start   = 1'b0;
            prog_we = 1'b0;

            ev = 1'b0;
            if (idx < n && !s) begin
                ev     = 1'b1;
                mdl_op = q_op[idx];
                idx++;
                if (idx == n) done_j = j + PD + 1;
            end
            epc = (idx < n) ? q_pc[idx] : 0;
            ed  = (j == done_j);
            eb  = (done_j < 0) || (j <= done_j);

            total++;
            if (inst_v !== ev) begin
                bad++;
                $display("FAIL inst_v cyc=%0d: got %b need %b", j, inst_v, ev);
            end
            total++;
            if (opcode !== mdl_op) begin
                bad++;
                $display("FAIL opcode cyc=%0d: got %b need %b", j, opcode, mdl_op);
            end
            total++;
            if (pc !== AW'(epc)) begin
                bad++;
                $display("FAIL pc cyc=%0d: got %0d need %0d", j, pc, epc);
            end
            total++;
            if (busy !== eb) begin
                bad++;
                $display("FAIL busy cyc=%0d: got %b need %b", j, busy, eb);
            end
            total++;
            if (done !== ed) begin
                bad++;
                $display("FAIL done cyc=%0d: got %b need %b", j, done, ed);
            end
            if (done_j >= 0 && j == done_j + 1) begin
                finished = 1'b1;
                break;
            end
        end
        stall = 1'b0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL run_timeout: issued %0d of %0d, need completion", idx, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        start = 1'b0; stall = 1'b0;
`ifdef PE_SEQ_LOOP_EN
        loop_cnt = '0;
`endif
        mdl_op = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (inst_v !== 1'b0 || opcode !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || pc !== '0) begin
            bad++;
            $display("FAIL reset_values: inst_v=%b op=%b busy=%b done=%b pc=%0d, need all 0",
                     inst_v, opcode, busy, done, pc);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        write_entry(0, 3'b001, 0);
        write_entry(1, 3'b100, 2);
        replay(2, 0, 0, 0, -1, 1'b0, 1'b0);
        replay(2, 0, 0, 2, 3, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        replay(0, 0, 0, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_rep_max();
        write_entry(0, 3'b111, 255);
        write_entry(1, 3'b010, 0);
        replay(2, 0, 10, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_full_depth();
        for (int e = 0; e < DEPTH; e++)
            write_entry(e, 3'($urandom_range(0, 7)), $urandom_range(0, 1));
        replay(DEPTH, 0, 20, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 6);
            for (int e = 0; e < len; e++)
                write_entry(e, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
            replay(len, 0, $urandom_range(0, 40), 0, -1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_start_write();
        write_entry(0, 3'b101, 1);
        write_entry(1, 3'b110, 0);
        replay(2, 0, 0, 0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_busy_intrude();
        write_entry(0, 3'b001, 2);
        write_entry(1, 3'b100, 2);
        write_entry(2, 3'b111, 2);
        replay(3, 0, 0, 0, -1, 1'b1, 1'b0);
        replay(3, 0, 0, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        write_entry(0, 3'b001, 0);
        write_entry(1, 3'b010, 0);
        write_entry(2, 3'b100, 0);
        write_entry(3, 3'b111, 0);
        write_entry(4, 3'b110, 0);
        @(negedge clk);
        start = 1'b1;
        prog_len = 5'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        mdl_op = 3'b000;
        total++;
        if (inst_v !== 1'b0 || busy !== 1'b0 || pc !== '0 || opcode !== 3'b000 || done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: inst_v=%b busy=%b pc=%0d op=%b done=%b, need all 0",
                     inst_v, busy, pc, opcode, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || inst_v !== 1'b0) begin
            bad++;
            $display("FAIL no_autorestart: busy=%b inst_v=%b need 0 0", busy, inst_v);
        end
        replay(5, 0, 0, 0, -1, 1'b0, 1'b0);
    endtask

`ifdef PE_SEQ_LOOP_EN
    task automatic test_loop();
        write_entry(0, 3'b010, 1);
        replay(1, 2, 0, 0, -1, 1'b0, 1'b0);
        write_entry(1, 3'b100, 0);
        replay(2, $urandom_range(1, 3), 25, 0, -1, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_empty();
        test_rep_max();
        test_full_depth();
        test_random();
        test_start_write();
        test_busy_intrude();
        test_reset_mid();
`ifdef PE_SEQ_LOOP_EN
        test_loop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_inst_sequencer.md
# pe_inst_sequencer

Instruction sequencer for one PE. It holds a small program of (opcode, repeat) entries and replays it on start by driving `inst_v`/`opcode` into the PE instruction decoder, one instruction per cycle. It honours a stall input and waits for the decoder's result pipeline to drain before signalling `done`. It sits between the host/array controller and the per-PE decode/feedback logic.

## Interface
- `INST_DEPTH`, 16: program entries; power of two, ≥2.
- `CNT_WIDTH`, 8: width of the per-entry repeat field.
- `PIPE_DELAY`, 7: decoder issue-to-`dout_v` latency in cycles; sets the drain length.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `prog_we` in 1: program write strobe; honoured only in IDLE.
- `prog_addr` in log2(INST_DEPTH): write address.
- `prog_data` in 3+CNT_WIDTH: {opcode[2:0], repeat}.
- `prog_len` in log2(INST_DEPTH)+1: number of valid entries, sampled on start; range 0..INST_DEPTH.
- `start` in 1: single-cycle start pulse; honoured only in IDLE.
- `stall` in 1: hold issue; no instruction is issued on an edge where `stall` is high.
- `inst_v` out 1: instruction valid to the decoder; registered.
- `opcode` out 3: opcode to the decoder; registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `pc` out log2(INST_DEPTH): index of the current entry.

## Operation
- Storage: INST_DEPTH × (3+CNT_WIDTH) register array. Written on edges where `prog_we` is high and state is IDLE. Writes in any other state are dropped.
- Each entry is issued repeat+1 times, back to back. Opcodes pass through unchanged: 001 ADD, 010 SUB, 100 MUL, 101 MULADD, 110 MULSUB, 111 MAX, others LOAD.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE on `start` with `prog_len`≠0. This edge latches `prog_len`, clears `pc` and the repeat counter.
  - IDLE → DONE on `start` with `prog_len`=0.
  - ISSUE: on each edge with `stall`=0, the block registers `inst_v`=1 and `opcode`=mem[pc].opcode, then advances. The repeat counter increments; at the entry's repeat value it clears and `pc` increments.
  - ISSUE: on an edge with `stall`=1, the block registers `inst_v`=0. `opcode`, `pc` and the counter hold.
  - ISSUE → DRAIN on the edge that issues the last repeat of entry `prog_len`-1.
  - DRAIN: `inst_v`=0; counts PIPE_DELAY cycles, then → DONE. `stall` is ignored.
  - DONE: `done`=1 for exactly one cycle, then → IDLE.
- `start` in any state other than IDLE is ignored. It is not queued.
- `repeat`=0 means a single issue. `repeat`=2^CNT_WIDTH-1 means 2^CNT_WIDTH issues. The counter must not wrap early.
- `pc` wraps only via the end-of-program check; it never indexes at or beyond `prog_len`.

## Timing
- Reset values: `inst_v`=0, `opcode`=000, `busy`=0, `done`=0, `pc`=0, state IDLE. Program storage is not reset; contents survive `rst`.
- `rst` asserted mid-program: outputs take their reset values immediately (asynchronously). Sequencing restarts only on a new `start`.
- `start` sampled at edge k → first `inst_v`=1 after edge k+1.
- Unstalled program of N total issues: `inst_v` is high for edges k+1..k+N. `done` is high after edge k+N+PIPE_DELAY+1, for one cycle. `busy` is high after edges k+1 through k+N+PIPE_DELAY+1 inclusive.
- Each stalled edge in ISSUE adds exactly one cycle to this schedule.
- `stall` asserted on the same edge as the last issue: the last issue is withheld and retried on the next unstalled edge.
- `start` and `prog_we` on the same IDLE edge: the write completes, and `start` uses the post-write contents from edge k+1 onward.

## Configuration
- `PE_SEQ_LOOP_EN` defined:
  - Adds input `loop_cnt` (CNT_WIDTH), sampled on `start`.
  - The full program is issued `loop_cnt`+1 times, back to back, with no gap between passes.
  - Drain and `done` occur once, after the final pass.
- `PE_SEQ_LOOP_EN` undefined: no `loop_cnt` port; single pass.

## Structure
- Shared package `pe_pkg`:
  - opcode constants OP_LOAD, OP_ADD, OP_SUB, OP_MUL, OP_MULADD, OP_MULSUB, OP_MAX;
  - sequencer state encoding;
  - instruction word field offsets.
- Sub-module `pe_inst_mem`: synchronous-write, asynchronous-read register file with no reset. The FSM, counters and output registers live in the top.

## Test plan
- Program {ADD rep 0, MUL rep 2}, `prog_len`=2, start at edge 10 → `inst_v` edges 11–14. Opcodes are 001,100,100,100. `done` pulses after edge 22 (4+7+1 past start).
- Same program, `stall` high for edges 12–13 → `inst_v` low on those two edges, no opcode skipped, `done` pulses after edge 24.
- `prog_len`=0, start at edge 5 → `inst_v` never rises. `done` is high after edge 6, and `busy` is high for exactly that cycle.
- `rst` pulsed during ISSUE → `inst_v`/`busy`/`pc` go to 0 immediately. A re-start replays the unchanged program from entry 0.
- `start` and `prog_we` asserted while busy → no restart, memory unchanged. Readback by a second run shows the original opcodes.
- With `PE_SEQ_LOOP_EN`, `loop_cnt`=2, one entry SUB rep 1 → six contiguous 010 issues, a single `done` 8 cycles after the last.
